// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    // Bits to shift for the next word: a full word, or whatever is left of the chain.
    function automatic int min_burst(input int word_w, input int remaining);
        return (remaining < word_w) ? remaining : word_w;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-side handshake bundle: configuration words in, readback words and status out.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 16
) ();
    logic              cfg_start;
    logic              cfg_abort;
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_word_valid;
    logic              cfg_word_ready;
    logic [WORD_W-1:0] rb_word;
    logic              rb_valid;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        output cfg_start, cfg_abort, cfg_word, cfg_word_valid,
        input  cfg_word_ready, rb_word, rb_valid, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_word, cfg_word_valid,
        output cfg_word_ready, rb_word, rb_valid, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/ccff_readback_deser.sv
// Collects bits leaving the chain tail into host words, first bit in the MSB;
// a flush emits a left-aligned, zero-filled partial word.
module ccff_readback_deser #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic              flush_i,
    input  logic              clear_i,
    input  logic              tail_i,
    output logic [WORD_W-1:0] rb_word_o,
    output logic              rb_valid_o
);
    localparam int FILL_W = $clog2(WORD_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);

    // Only WORD_W-1 bits are ever parked; the last bit goes straight into the word.
    logic [WORD_W-2:0] sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] sr_next_s;

    assign sr_next_s  = {sr_q, tail_i};
    assign rb_word_o  = word_q;
    assign rb_valid_o = valid_q;

    // Next-state logic: shift in a tail bit, emit on a full word or on flush.
    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            sr_d   = '0;
            fill_d = '0;
            word_d = '0;
        end else if (shift_i) begin
            if (fill_q == FILL_LAST) begin
                word_d  = sr_next_s;
                valid_d = 1'b1;
                sr_d    = '0;
                fill_d  = '0;
            end else if (flush_i) begin
                word_d  = sr_next_s << (FILL_LAST - fill_q);
                valid_d = 1'b1;
                sr_d    = '0;
                fill_d  = '0;
            end else begin
                sr_d   = sr_next_s[WORD_W-2:0];
                fill_d = fill_q + FILL_W'(1);
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes host words onto a configuration chain head (MSB first) for exactly
// CHAIN_LEN bits, while collecting the old chain contents from the tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                     prog_clk,
    input  logic                     prog_reset,
    ccff_bitstream_loader_if.slave   host,
    output logic                     ccff_head,
    output logic                     ccff_shift_en,
    input  logic                     ccff_tail
);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    ccff_state_e       state_q, state_d;
    // Holds the not-yet-presented bits of the current word, left-aligned.
    logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  bits_sent_q, bits_sent_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rb_shift_s, rb_flush_s, rb_clear_s;

    assign ccff_head           = head_q;
    assign ccff_shift_en       = shift_en_q;
    assign host.cfg_word_ready = ready_q;
    assign host.cfg_busy       = busy_q;
    assign host.cfg_done       = done_q;
    assign host.cfg_err        = err_q;

    // Loader FSM next state; head/shift_en are computed one cycle ahead so they register together.
    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        burst_d     = burst_q;
        burst_cnt_d = burst_cnt_q;
        bits_sent_d = bits_sent_q;
        head_d      = 1'b0;
        shift_en_d  = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        rb_shift_s  = 1'b0;
        rb_flush_s  = 1'b0;
        rb_clear_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (host.cfg_start) begin
                    state_d     = ST_LOAD;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    bits_sent_d = '0;
                    rb_clear_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (host.cfg_abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    done_d     = 1'b0;
                    rb_clear_s = 1'b1;
                end else if (host.cfg_word_valid && ready_q) begin
                    state_d     = ST_SHIFT;
                    shift_reg_d = {host.cfg_word[WORD_W-2:0], 1'b0};
                    burst_d     = CNT_W'(min_burst(WORD_W, CHAIN_LEN - int'(bits_sent_q)));
                    burst_cnt_d = '0;
                    head_d      = host.cfg_word[WORD_W-1];
                    shift_en_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (host.cfg_abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    done_d     = 1'b0;
                    rb_clear_s = 1'b1;
                end else begin
                    rb_shift_s  = 1'b1;
                    shift_reg_d = {shift_reg_q[WORD_W-2:0], 1'b0};
                    bits_sent_d = bits_sent_q + ONE_C;
                    burst_cnt_d = burst_cnt_q + ONE_C;
                    if (burst_cnt_q == (burst_q - ONE_C)) begin
                        if (bits_sent_d == CHAIN_LEN_C) begin
                            state_d    = ST_DONE;
                            done_d     = 1'b1;
                            rb_flush_s = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        head_d     = shift_reg_q[WORD_W-1];
                        shift_en_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    // State and registered outputs.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            shift_reg_q <= '0;
            burst_q     <= '0;
            burst_cnt_q <= '0;
            bits_sent_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            burst_q     <= burst_d;
            burst_cnt_q <= burst_cnt_d;
            bits_sent_q <= bits_sent_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    ccff_readback_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk        (prog_clk),
        .rst        (prog_reset),
        .shift_i    (rb_shift_s),
        .flush_i    (rb_flush_s),
        .clear_i    (rb_clear_s),
        .tail_i     (ccff_tail),
        .rb_word_o  (host.rb_word),
        .rb_valid_o (host.rb_valid)
    );
endmodule
